// File: rtl/sort_pkg.sv
// Shared defaults and types for the sorted drain buffer.
package sort_pkg;
    localparam int DATA_W_DEF = 7;
    localparam int DEPTH_DEF  = 15;

    typedef logic [DATA_W_DEF-1:0] data_t;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;
endpackage

// File: rtl/sort_cell.sv
// One slot of the insertion-sort array: holds a value, shifts up on insert
// (when the slot to its left is already greater than the new value) or down on pop.
module sort_cell #(
    parameter int DATA_W = sort_pkg::DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ins_en,
    input  logic              shd_en,
    input  logic              occupied,
    input  logic [DATA_W-1:0] left_val,
    input  logic [DATA_W-1:0] right_val,
    input  logic [DATA_W-1:0] new_val,
    input  logic              left_gt,
    output logic [DATA_W-1:0] val,
    output logic              gt
);
    logic [DATA_W-1:0] val_reg;

    // An empty slot behaves as +infinity, so the first empty slot claims the
    // new value when no occupied slot is greater; equal values stay behind.
    assign gt  = !occupied || (val_reg > new_val);
    assign val = val_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_reg <= '0;
        end else if (ins_en) begin
            if (left_gt) begin
                val_reg <= left_val;
            end else if (gt) begin
                val_reg <= new_val;
            end
        end else if (shd_en) begin
            val_reg <= right_val;
        end
    end
endmodule

// File: rtl/sorted_drain_buffer.sv
// Collects a batch of values kept in ascending order on arrival, then drains
// them smallest-first on a valid/ready stream.
module sorted_drain_buffer
    import sort_pkg::*;
#(
    parameter int DATA_W = sort_pkg::DATA_W_DEF,
    parameter int DEPTH  = sort_pkg::DEPTH_DEF,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [CNT_W-1:0]  count
);
    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [DATA_W-1:0] slot_val [DEPTH];
    logic              slot_gt  [DEPTH];
    logic              accept;
    logic              pop;

    assign in_ready  = (state_reg == FILL) && (count_reg < CNT_W'(DEPTH));
    assign out_valid = (state_reg == DRAIN);
    assign out_data  = out_valid ? slot_val[0] : '0;
    assign out_last  = out_valid && (count_reg == CNT_W'(1));
    assign count     = count_reg;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
            logic [DATA_W-1:0] left_val;
            logic [DATA_W-1:0] right_val;
            logic              left_gt;

            if (gi == 0) begin : g_first
                assign left_val = '0;
                assign left_gt  = 1'b0;
            end else begin : g_mid
                assign left_val = slot_val[gi-1];
                assign left_gt  = slot_gt[gi-1];
            end

            // The top slot refills with zero on pop so unused slots stay clear.
            if (gi == DEPTH - 1) begin : g_last
                assign right_val = '0;
            end else begin : g_inner
                assign right_val = slot_val[gi+1];
            end

            sort_cell #(
                .DATA_W (DATA_W)
            ) u_cell (
                .clk       (clk),
                .rst_n     (rst_n),
                .ins_en    (accept),
                .shd_en    (pop),
                .occupied  (CNT_W'(gi) < count_reg),
                .left_val  (left_val),
                .right_val (right_val),
                .new_val   (in_data),
                .left_gt   (left_gt),
                .val       (slot_val[gi]),
                .gt        (slot_gt[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= FILL;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            FILL: begin
                if (accept) begin
                    count_next = count_reg + CNT_W'(1);
                    if (in_last || (count_reg == CNT_W'(DEPTH - 1))) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop) begin
                    count_next = count_reg - CNT_W'(1);
                    if (count_reg == CNT_W'(1)) begin
                        state_next = FILL;
                    end
                end
            end
            default: begin
                state_next = FILL;
                count_next = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_sorted_drain_buffer.sv
// Scoreboard bench for sorted_drain_buffer: a sorted model queue is built as
// values are pushed and popped against the DUT output stream.
module tb_sorted_drain_buffer;
    localparam int DATA_W = 7;
    localparam int DEPTH  = 15;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic [CNT_W-1:0]  count;

    int checks = 0;
    int errors = 0;
    int mq[$];

    sorted_drain_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model insertion: after every equal value already held.
    task automatic model_insert(input int d);
        int pos;
        pos = mq.size();
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i] > d) begin
                pos = i;
                break;
            end
        end
        mq.insert(pos, d);
    endtask

    task automatic send(input int d, input bit last);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = DATA_W'(d);
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", 0, 1);
        end else begin
            check("fill_count", int'(count), mq.size());
            model_insert(d);
            $display("PUSH %0d last=%0b", d, last);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(input int n_pop, input bit rnd, input bit full);
        int  cyc;
        int  exp;
        int  held_d;
        int  held_l;
        bit  stalled;
        bit  first;
        int  left;
        cyc     = 0;
        stalled = 1'b0;
        first   = 1'b1;
        held_d  = 0;
        held_l  = 0;
        left    = n_pop;
        while (left > 0) begin
            out_ready = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
            @(negedge clk);
            if (first) begin
                check("valid_after_close", int'(out_valid), 1);
                first = 1'b0;
            end
            if (out_valid) begin
                check("in_ready_drain", int'(in_ready), 0);
                check("drain_count", int'(count), mq.size());
                if (stalled) begin
                    check("stall_data", int'(out_data), held_d);
                    check("stall_last", int'(out_last), held_l);
                end
                if (mq.size() == 0) begin
                    check("extra_output", 1, 0);
                    break;
                end
                if (out_ready) begin
                    exp = mq.pop_front();
                    check("out_data", int'(out_data), exp);
                    check("out_last", int'(out_last), int'(mq.size() == 0));
                    $display("POP %0d last=%0b", out_data, out_last);
                    left--;
                    stalled = 1'b0;
                    if (mq.size() == 0) in_valid = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held_d  = int'(out_data);
                    held_l  = int'(out_last);
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            if (cyc > 200) begin
                check("drain_timeout", 0, 1);
                break;
            end
        end
        out_ready = 1'b0;
        if (full) begin
            @(negedge clk);
            check("ready_after_pop", int'(in_ready), 1);
            check("idle_valid", int'(out_valid), 0);
            check("idle_count", int'(count), 0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int full_set[15];
        int mid_set[10];
        full_set = '{4, 80, 13, 27, 35, 67, 31, 43, 67, 42, 72, 75, 84, 36, 14};
        mid_set  = '{55, 3, 90, 17, 17, 64, 8, 120, 41, 29};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_count", int'(count), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full batch closes on reaching DEPTH.
        foreach (full_set[i]) send(full_set[i], 1'b0);
        drain(15, 1'b0, 1'b1);

        // Short batch.
        send(50, 1'b0);
        send(10, 1'b0);
        send(30, 1'b1);
        drain(3, 1'b0, 1'b1);

        // Single value.
        send(100, 1'b1);
        drain(1, 1'b0, 1'b1);

        // Backpressure with a producer pushing during drain.
        send(9, 1'b0);
        send(1, 1'b0);
        send(9, 1'b0);
        send(1, 1'b0);
        send(5, 1'b1);
        in_valid = 1'b1;
        in_data  = 7'd3;
        in_last  = 1'b0;
        drain(5, 1'b1, 1'b1);
        in_valid = 1'b0;

        // Duplicates and extremes.
        send(0, 1'b0);
        send(127, 1'b0);
        send(127, 1'b0);
        send(0, 1'b1);
        drain(4, 1'b0, 1'b1);

        // Reset after three pops of a ten-value batch.
        foreach (mid_set[i]) send(mid_set[i], i == 9);
        drain(3, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_count", int'(count), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_out_data", int'(out_data), 0);
        mq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(77, 1'b0);
        send(6, 1'b1);
        drain(2, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sorted_drain_buffer.md
# sorted_drain_buffer

Batch collector that accepts a stream of unsigned values, keeps them sorted in ascending order as they arrive, and then drains the batch in ascending order on a valid/ready output stream. It is the consumer side of the random-fill/resize/sort flow. A producer pushes up to DEPTH values, and downstream logic reads them back sorted without a separate sort pass. It sits between a value generator (e.g. an LFSR range source) and any checker or scoreboard that expects ordered data.

## Interface
- DATA_W, 7, width of each value (covers 1–100; any DATA_W-bit value is legal).
- DEPTH, 15, maximum batch size; must be ≥ 2.
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a value.
- in_ready  output  1  buffer can accept a value.
- in_data  input  DATA_W  value to insert.
- in_last  input  1  final value of the batch; qualified by in_valid.
- out_valid  output  1  sorted value available.
- out_ready  input  1  consumer takes the value.
- out_data  output  DATA_W  current smallest remaining value.
- out_last  output  1  out_data is the final value of the batch.
- count  output  $clog2(DEPTH+1)  number of values currently held.

## Operation
- Two states: FILL (reset state) and DRAIN.
- FILL:
  - in_ready = 1 iff count < DEPTH.
  - out_valid = 0.
  - An accepted value (in_valid & in_ready) is inserted into slot k. Slot k is the first slot whose value is strictly greater than in_data, so equal values keep arrival order.
  - Slots k..count-1 shift up one place and count increments.
  - FILL → DRAIN on an accepted beat with in_last = 1, or on an accepted beat that makes count == DEPTH.
- DRAIN:
  - in_ready = 0.
  - out_valid = 1.
  - out_data = slot[0].
  - out_last = (count == 1).
  - On out_valid & out_ready, all slots shift down one place and count decrements.
  - The pop with out_last = 1 returns the block to FILL with count = 0.
- The batch always holds ≥ 1 value, because entry to DRAIN requires an accepted beat.
- Unused slots hold 0 and are never compared: insertion compares only slots < count.
- No arithmetic on the data. The only comparison is an unsigned DATA_W compare.

## Timing
- Reset (asynchronous, rst_n low) values:
  - state = FILL, count = 0, all slots = 0.
  - in_ready = 1, out_valid = 0, out_data = 0, out_last = 0.
- Insert takes one cycle. A value accepted in cycle n is placed in its sorted slot and reflected in count at cycle n+1.
- Back-to-back accepts every cycle are supported.
- Transition latency: after the closing accept in cycle n, the block is in DRAIN with out_valid = 1 at cycle n+1.
- Drain throughput is one value per cycle while out_ready is held high.
- Holding rules:
  - out_data and out_last hold stable while out_valid & !out_ready.
  - in_ready depends only on registered state, never combinationally on in_valid.
- After the final pop in cycle m, in_ready = 1 at cycle m+1. There is no accept in the same cycle as the final pop.
- Full: at count == DEPTH, in_ready = 0. That state only occurs in DRAIN, because reaching DEPTH forces the transition.
- An in_valid asserted while in DRAIN is ignored and must be held by the producer.
- Reset mid-operation, in either state, discards the batch immediately. Outputs take their reset values asynchronously.

## Structure
- Package sort_pkg holds:
  - DATA_W and DEPTH defaults.
  - typedef data_t (logic [DATA_W-1:0]).
  - enum state_t {FILL, DRAIN}.
- Sub-module sort_cell: one slot register.
  - Inputs: insert/shift-down enables, left-neighbour value, right-neighbour value, new value, and a "greater than new" flag from its left neighbour.
  - Outputs: its own value and its own "greater than new" flag.
- sorted_drain_buffer instantiates DEPTH sort_cell instances in a generate loop, plus the FSM and counter.

## Test plan
- Full batch: push 4,80,13,27,35,67,31,43,67,42,72,75,84,36,14 back-to-back, no in_last.
  - in_ready drops after the 15th beat.
  - Drain yields 4,13,14,27,31,35,36,42,43,67,67,72,75,80,84.
  - out_last is set only on 84, and count steps 15→0.
- Short batch: push 50,10,30 with in_last on 30 → drain 10,30,50, out_last on 50. in_ready = 1 the cycle after the final pop.
- Single value: push 100 with in_last → out_valid the next cycle with out_data = 100 and out_last = 1.
- Backpressure: 5-value batch 9,1,9,1,5, with out_ready toggled randomly → output 1,1,5,9,9, with data stable during stalls. in_valid during DRAIN is ignored.
- Duplicates and extremes: push 0,127,127,0 with in_last → 0,0,127,127.
- Reset mid-drain: assert rst_n low after 3 pops of a 10-value batch → count = 0, out_valid = 0, in_ready = 1. A following 2-value batch drains correctly with no stale data.
